// File: rtl/tetris_pkg.sv
// Shared constants and the queue FSM state type used by the piece queue
// and its storage sub-module.
package tetris_pkg;
    localparam int PIECE_W        = 3;
    localparam int NUM_PIECES_DEF = 5;
    localparam int QUEUE_DEPTH    = 4;
    localparam int CNT_W          = 4;

    typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/piece_queue_if.sv
// Random-candidate input, consume request, and head/preview/count outputs
// of the piece queue, bundled as one interface.
interface piece_queue_if;
    logic [31:0]                    rand_data;
    logic                           piece_req;
    logic                           piece_valid;
    logic [tetris_pkg::PIECE_W-1:0] piece_id;
    logic [tetris_pkg::PIECE_W-1:0] next_id;
    logic [tetris_pkg::CNT_W-1:0]   count;

    modport master (output rand_data, piece_req,
                    input  piece_valid, piece_id, next_id, count);
    modport slave  (input  rand_data, piece_req,
                    output piece_valid, piece_id, next_id, count);
endinterface

// File: rtl/piece_queue_fifo.sv
// piece_fifo: circular piece storage with wrapping pointers and an occupancy
// count; head and preview entries are read straight out of the registers.
module piece_fifo
    import tetris_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [PIECE_W-1:0] data_i,
    output logic [PIECE_W-1:0] head_o,
    output logic [PIECE_W-1:0] next_o,
    output logic [CNT_W-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][PIECE_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]              rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          push_ok, pop_ok;

    // Guards here keep count inside 0..DEPTH whatever the caller asks for.
    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop_ok) rd_d = rd_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign next_o  = mem_q[rd_q + PTR_W'(1)];
    assign count_o = cnt_q;
endmodule

// File: rtl/piece_queue.sv
// piece_queue: settle-time FSM and candidate acceptance filter in front of
// piece_fifo. Define PIECE_NO_REPEAT_EN to reject a repeat of the last pushed ID.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH      = QUEUE_DEPTH,
    parameter int NUM_PIECES = NUM_PIECES_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    piece_queue_if.slave  bus
);
    state_e             state_q, state_d;
    logic               init_cnt_q, init_cnt_d;
    logic               in_range, accept, pop, push, full;
    logic [PIECE_W-1:0] head, nxt;
    logic [CNT_W-1:0]   cnt;

    assign in_range = bus.rand_data < 32'(NUM_PIECES);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign pop      = bus.piece_req && bus.piece_valid;
    assign push     = accept && (!full || pop);

`ifdef PIECE_NO_REPEAT_EN
    logic [PIECE_W-1:0] last_q, last_d;

    // 3'd7 is never a legal ID, so the first candidate always passes.
    assign accept = (state_q == RUN) && in_range && (bus.rand_data[PIECE_W-1:0] != last_q);

    always_comb begin
        last_d = last_q;
        if (push) last_d = bus.rand_data[PIECE_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_q <= 3'd7;
        else         last_q <= last_d;
    end
`else
    assign accept = (state_q == RUN) && in_range;
`endif

    // Two settle cycles while the generator output is meaningless.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = 1'b1;
                if (init_cnt_q) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= INIT;
            init_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    piece_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (bus.rand_data[PIECE_W-1:0]),
        .head_o  (head),
        .next_o  (nxt),
        .count_o (cnt)
    );

    assign bus.piece_valid = (state_q == RUN) && (cnt != '0);
    assign bus.piece_id    = head;
    assign bus.next_id     = nxt;
    assign bus.count       = cnt;
endmodule
